// File: rtl/packet_ejector_pkg.sv
// Shared types and helpers for the Hermes NoC packet ejector.
// Header address layout is {x, y} in the low 16 bits of the header flit.
package HermesPkg;

    typedef enum logic [2:0] {
        HEADER,
        SIZE,
        PAYLOAD,
        DROP_SIZE,
        DROP
    } ejector_state_t;

    localparam int ADDR_X_MSB = 15;
    localparam int ADDR_X_LSB = 8;
    localparam int ADDR_Y_MSB = 7;
    localparam int ADDR_Y_LSB = 0;

    function automatic logic addr_match(input logic [15:0] hdr, input logic [15:0] addr);
        return (hdr[ADDR_X_MSB:ADDR_X_LSB] == addr[ADDR_X_MSB:ADDR_X_LSB]) &&
               (hdr[ADDR_Y_MSB:ADDR_Y_LSB] == addr[ADDR_Y_MSB:ADDR_Y_LSB]);
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/packet_ejector_fifo.sv
// Circular flit FIFO, head visible the cycle after the first push into an empty buffer.
// Push is ignored when full, pop ignored when empty; simultaneous push/pop keeps count.
module ejector_fifo #(
    parameter int FLIT_SIZE   = 32,
    parameter int BUFFER_SIZE = 8
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             push,
    input  logic [FLIT_SIZE-1:0]             push_data,
    input  logic                             pop,
    output logic [FLIT_SIZE-1:0]             pop_data,
    output logic                             full,
    output logic                             empty,
    output logic [$clog2(BUFFER_SIZE):0]     count
);

    localparam int PTR_W = $clog2(BUFFER_SIZE);
    localparam int CNT_W = PTR_W + 1;

    logic [FLIT_SIZE-1:0] mem [BUFFER_SIZE];
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic                 do_push;
    logic                 do_pop;

    assign full     = (count == CNT_W'(BUFFER_SIZE));
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    // Empty buffer presents zero so the sink data bus is clean out of reset.
    assign pop_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/packet_ejector.sv
// NoC ejector: parses header/size, forwards size+payload of packets addressed here, drops others.
// Sink sees a flit one cycle after acceptance; NoC credit falls while forwarding into a full FIFO.
module packet_ejector
    import HermesPkg::*;
#(
    parameter logic [15:0] EJECTOR_ADDRESS = 16'h0000,
    parameter int          FLIT_SIZE       = 32,
    parameter int          BUFFER_SIZE     = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 noc_rx_i,
    output logic                 noc_credit_o,
    input  logic [FLIT_SIZE-1:0] noc_data_i,
    output logic                 snk_tx_o,
    input  logic                 snk_credit_i,
    output logic [FLIT_SIZE-1:0] snk_data_o,
    output logic [15:0]          pkt_count_o,
    output logic [15:0]          drop_count_o
);

    localparam int CNT_W = $clog2(BUFFER_SIZE) + 1;

    ejector_state_t       state;
    logic [FLIT_SIZE-1:0] remaining;
    logic                 accept;
    logic                 forwarding;
    logic                 fifo_push;
    logic                 fifo_pop;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [CNT_W-1:0]     fifo_count;

    assign forwarding = (state == SIZE) || (state == PAYLOAD);

    always_comb begin
        noc_credit_o = 1'b1;
        if (forwarding) begin
            noc_credit_o = (fifo_count != CNT_W'(BUFFER_SIZE));
        end
    end

    assign accept    = noc_rx_i && noc_credit_o;
    assign fifo_push = accept && forwarding && !fifo_full;
    assign fifo_pop  = snk_tx_o && snk_credit_i;
    assign snk_tx_o  = !fifo_empty;

    ejector_fifo #(
        .FLIT_SIZE   (FLIT_SIZE),
        .BUFFER_SIZE (BUFFER_SIZE)
    ) u_fifo (
        .clk       (clk_i),
        .rst       (rst_i),
        .push      (fifo_push),
        .push_data (noc_data_i),
        .pop       (fifo_pop),
        .pop_data  (snk_data_o),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state        <= HEADER;
            remaining    <= '0;
            pkt_count_o  <= '0;
            drop_count_o <= '0;
        end else if (accept) begin
            case (state)
                HEADER: begin
                    state <= addr_match(noc_data_i[15:0], EJECTOR_ADDRESS) ? SIZE : DROP_SIZE;
                end
                SIZE: begin
                    remaining <= noc_data_i;
                    if (noc_data_i == '0) begin
                        state       <= HEADER;
                        pkt_count_o <= sat_inc(pkt_count_o);
                    end else begin
                        state <= PAYLOAD;
                    end
                end
                PAYLOAD: begin
                    remaining <= remaining - FLIT_SIZE'(1);
                    if (remaining == FLIT_SIZE'(1)) begin
                        state       <= HEADER;
                        pkt_count_o <= sat_inc(pkt_count_o);
                    end
                end
                DROP_SIZE: begin
                    remaining <= noc_data_i;
                    if (noc_data_i == '0) begin
                        state        <= HEADER;
                        drop_count_o <= sat_inc(drop_count_o);
                    end else begin
                        state <= DROP;
                    end
                end
                DROP: begin
                    remaining <= remaining - FLIT_SIZE'(1);
                    if (remaining == FLIT_SIZE'(1)) begin
                        state        <= HEADER;
                        drop_count_o <= sat_inc(drop_count_o);
                    end
                end
                default: state <= HEADER;
            endcase
        end
    end

endmodule

// File: tb/tb_packet_ejector.sv
// Scoreboard bench for packet_ejector: stimulus queues expected sink flits, a negedge monitor checks them.
module tb_packet_ejector;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        noc_rx_i;
    logic        noc_credit_o;
    logic [31:0] noc_data_i;
    logic        snk_tx_o;
    logic        snk_credit_i;
    logic [31:0] snk_data_o;
    logic [15:0] pkt_count_o;
    logic [15:0] drop_count_o;

    int          n_cmp  = 0;
    int          n_fail = 0;
    logic [31:0] exp_q[$];
    int          exp_pkt;
    int          exp_drop;
    logic        stall_prev = 1'b0;
    logic [31:0] held_dat   = '0;

    packet_ejector #(
        .EJECTOR_ADDRESS (16'h0000),
        .FLIT_SIZE       (32),
        .BUFFER_SIZE     (8)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .noc_rx_i     (noc_rx_i),
        .noc_credit_o (noc_credit_o),
        .noc_data_i   (noc_data_i),
        .snk_tx_o     (snk_tx_o),
        .snk_credit_i (snk_credit_i),
        .snk_data_o   (snk_data_o),
        .pkt_count_o  (pkt_count_o),
        .drop_count_o (drop_count_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Sink monitor: every handshake pops one expected flit; a stalled head must not move.
    always @(negedge clk_i) begin
        if (snk_tx_o && snk_credit_i) begin
            if (exp_q.size() == 0) begin
                check("unexpected_sink_flit", snk_data_o, 32'hDEAD_BEEF);
            end else begin
                check("sink_flit", snk_data_o, exp_q.pop_front());
            end
        end
        if (stall_prev && snk_tx_o) begin
            check("stall_hold", snk_data_o, held_dat);
        end
        stall_prev = snk_tx_o && !snk_credit_i;
        held_dat   = snk_data_o;
    end

    task automatic send(input logic [31:0] f, output int waits);
        logic acc;
        logic done;
        noc_rx_i   = 1'b1;
        noc_data_i = f;
        waits      = 0;
        done       = 1'b0;
        while (!done) begin
            @(negedge clk_i);
            acc = noc_credit_o;
            @(posedge clk_i);
            #1;
            if (acc) begin
                done = 1'b1;
            end else begin
                waits++;
                if (waits > 300) begin
                    check("send_timeout", 32'(waits), 32'd0);
                    done = 1'b1;
                end
            end
        end
        noc_rx_i = 1'b0;
    endtask

    task automatic send_nw(input logic [31:0] f);
        int w;
        send(f, w);
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(posedge clk_i);
            #1;
            n++;
        end
        check("drain_left", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic check_counts(input string tag);
        check({tag, "_pkt"}, {16'h0, pkt_count_o}, 32'(exp_pkt));
        check({tag, "_drop"}, {16'h0, drop_count_o}, 32'(exp_drop));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        rst_i        = 1'b1;
        noc_rx_i     = 1'b0;
        noc_data_i   = '0;
        snk_credit_i = 1'b1;
        exp_pkt      = 0;
        exp_drop     = 0;
        repeat (3) @(posedge clk_i);
        #1;
        rst_i = 1'b0;

        check("rst_snk_tx", {31'h0, snk_tx_o}, 32'd0);
        check("rst_credit", {31'h0, noc_credit_o}, 32'd1);
        check("rst_snk_data", snk_data_o, 32'd0);
        check_counts("rst");

        // Matching packet
        exp_q.push_back(32'd3);
        exp_q.push_back(32'hA1);
        exp_q.push_back(32'hA2);
        exp_q.push_back(32'hA3);
        send_nw(32'h0000_0000);
        send_nw(32'd3);
        send_nw(32'hA1);
        send_nw(32'hA2);
        send_nw(32'hA3);
        drain();
        exp_pkt = 1;
        check_counts("match");

        // Mismatching packet: never backpressured, nothing reaches the sink
        send(32'h0000_0102, w); check("drop_hdr_wait", 32'(w), 32'd0);
        send(32'd2, w);         check("drop_size_wait", 32'(w), 32'd0);
        send(32'hB1, w);        check("drop_b1_wait", 32'(w), 32'd0);
        send(32'hB2, w);        check("drop_b2_wait", 32'(w), 32'd0);
        repeat (3) @(posedge clk_i);
        #1;
        check("drop_no_tx", {31'h0, snk_tx_o}, 32'd0);
        exp_drop = 1;
        check_counts("mismatch");

        // Zero-size packet followed back-to-back by a one-flit packet
        exp_q.push_back(32'd0);
        exp_q.push_back(32'd1);
        exp_q.push_back(32'hD1);
        send_nw(32'h0000_0000);
        send_nw(32'd0);
        send_nw(32'h0000_0000);
        send_nw(32'd1);
        send_nw(32'hD1);
        drain();
        exp_pkt = 3;
        check_counts("zero_size");

        // Backpressure: size 10, sink stalled
        snk_credit_i = 1'b0;
        exp_q.push_back(32'd10);
        for (int i = 0; i < 10; i++) exp_q.push_back(32'hE0 + 32'(i));
        send_nw(32'h0000_0000);
        send(32'd10, w);
        check("bp_size_wait", 32'(w), 32'd0);
        for (int i = 0; i < 7; i++) begin
            send(32'hE0 + 32'(i), w);
            check("bp_fill_wait", 32'(w), 32'd0);
        end
        @(negedge clk_i);
        check("bp_credit_low", {31'h0, noc_credit_o}, 32'd0);
        check("bp_tx_high", {31'h0, snk_tx_o}, 32'd1);
        fork
            begin
                repeat (4) @(posedge clk_i);
                #1;
                snk_credit_i = 1'b1;
            end
        join_none
        send(32'hE7, w);
        check("bp_resume_waited", {31'h0, (w > 0)}, 32'd1);
        send_nw(32'hE8);
        send_nw(32'hE9);
        drain();
        exp_pkt = 4;
        check_counts("backpressure");

        // Reset in the middle of a size-5 packet
        exp_q.push_back(32'd5);
        exp_q.push_back(32'hF1);
        exp_q.push_back(32'hF2);
        send_nw(32'h0000_0000);
        send_nw(32'd5);
        send_nw(32'hF1);
        send_nw(32'hF2);
        rst_i      = 1'b1;
        noc_rx_i   = 1'b1;
        noc_data_i = 32'h0000_0055;
        @(posedge clk_i);
        #1;
        rst_i    = 1'b0;
        noc_rx_i = 1'b0;
        check("midrst_q_empty", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        exp_pkt  = 0;
        exp_drop = 0;
        check("midrst_snk_tx", {31'h0, snk_tx_o}, 32'd0);
        check("midrst_credit", {31'h0, noc_credit_o}, 32'd1);
        check_counts("midrst");
        exp_q.push_back(32'd1);
        exp_q.push_back(32'hC1);
        send_nw(32'h0000_0000);
        send_nw(32'd1);
        send_nw(32'hC1);
        drain();
        exp_pkt = 1;
        check_counts("post_rst");

        // Full-rate streaming: occupancy stays at one flit
        exp_q.push_back(32'd20);
        for (int i = 0; i < 20; i++) exp_q.push_back(32'h100 + 32'(i));
        send_nw(32'h0000_0000);
        send(32'd20, w);
        check("stream_size_count", {28'h0, dut.fifo_count}, 32'd1);
        for (int i = 0; i < 20; i++) begin
            send(32'h100 + 32'(i), w);
            check("stream_wait", 32'(w), 32'd0);
            check("stream_count", {28'h0, dut.fifo_count}, 32'd1);
        end
        drain();
        exp_pkt = 2;
        check_counts("stream");

        // Drop counter saturation, preloaded near the ceiling
        force dut.drop_count_o = 16'hFFFD;
        #1;
        release dut.drop_count_o;
        check("sat_preload", {16'h0, drop_count_o}, 32'h0000_FFFD);
        send_nw(32'h0000_0102);
        send_nw(32'd0);
        check("sat_fffe", {16'h0, drop_count_o}, 32'h0000_FFFE);
        for (int i = 0; i < 3; i++) begin
            send_nw(32'h0000_0102);
            send_nw(32'd0);
            check("sat_hold", {16'h0, drop_count_o}, 32'h0000_FFFF);
        end
        check("sat_pkt_unchanged", {16'h0, pkt_count_o}, 32'd2);

        repeat (3) @(posedge clk_i);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
